// File: rtl/pipelined_controller.sv
// Control path for the 5-stage pipelined RV32I core: Decode-stage instruction decode
// plus the D/E, E/M and M/W control pipeline registers and Execute-stage PC-source select.

module single_cycle_controller #(
  parameter int ALU_CTRL_W   = 3,
  parameter int IMM_SRC_W    = 3,
  parameter int RESULT_SRC_W = 2
) (
  input  logic [6:0]              opcode,
  input  logic [2:0]              f3,
  input  logic                    f7_5,
  output logic                    reg_write,
  output logic [RESULT_SRC_W-1:0] result_src,
  output logic                    mem_write,
  output logic                    jump,
  output logic                    branch,
  output logic                    beq,
  output logic                    bne,
  output logic [ALU_CTRL_W-1:0]   alu_control,
  output logic                    alu_src,
  output logic                    jalr,
  output logic [IMM_SRC_W-1:0]    imm_src,
  output logic                    illegal_op
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {ALU_OP_ADD = 2'b00, ALU_OP_SUB = 2'b01, ALU_OP_FUNC = 2'b10} alu_op_e;
  alu_op_e alu_op;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    reg_write  = 1'b0;
    result_src = '0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    jalr       = 1'b0;
    imm_src    = '0;
    illegal_op = 1'b0;
    alu_op     = ALU_OP_ADD;
    unique case (opcode)
      OP_R:      begin reg_write = 1'b1; alu_op = ALU_OP_FUNC; end
      OP_I:      begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_OP_FUNC; end
      OP_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RESULT_SRC_W'(2'b01); end
      OP_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_SRC_W'(3'b001); end
      OP_BRANCH: begin branch = 1'b1; imm_src = IMM_SRC_W'(3'b010); alu_op = ALU_OP_SUB; end
      OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; imm_src = IMM_SRC_W'(3'b011);
                       result_src = RESULT_SRC_W'(2'b10); end
      OP_JALR:   begin reg_write = 1'b1; jalr = 1'b1; alu_src = 1'b1;
                       result_src = RESULT_SRC_W'(2'b10); end
      OP_LUI:    begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_SRC_W'(3'b100); end
      default:   illegal_op = 1'b1;
    endcase
  end

  assign beq = branch && (f3 == 3'b000);
  assign bne = branch && (f3 == 3'b001);

  always_comb begin
    alu_control = ALU_CTRL_W'(3'b000);
    case (alu_op)
      ALU_OP_SUB:  alu_control = ALU_CTRL_W'(3'b001);
      ALU_OP_FUNC: begin
        case (f3)
          // Only register-register forms with f7[5] set subtract; addi never does.
          3'b000:  alu_control = (opcode[5] && f7_5) ? ALU_CTRL_W'(3'b001) : ALU_CTRL_W'(3'b000);
          3'b010:  alu_control = ALU_CTRL_W'(3'b101);
          3'b110:  alu_control = ALU_CTRL_W'(3'b011);
          3'b111:  alu_control = ALU_CTRL_W'(3'b010);
          default: alu_control = ALU_CTRL_W'(3'b000);
        endcase
      end
      default:     alu_control = ALU_CTRL_W'(3'b000);
    endcase
  end

endmodule

module pipelined_controller #(
  parameter int ALU_CTRL_W   = 3,
  parameter int IMM_SRC_W    = 3,
  parameter int RESULT_SRC_W = 2,
  parameter bit ENABLE_LT    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              opcode,
  input  logic [2:0]              f3,
  input  logic [6:0]              f7,
  input  logic                    FlushE,
  input  logic                    ZeroE,
  input  logic                    LtE,
  output logic [IMM_SRC_W-1:0]    ImmSrcD,
  output logic                    IllegalD,
  output logic [ALU_CTRL_W-1:0]   ALUControlE,
  output logic                    ALUSrcE,
  output logic                    ResultSrcE0,
  output logic                    RegWriteE,
  output logic [1:0]              PCSrcE,
  output logic                    MemWriteM,
  output logic                    RegWriteM,
  output logic                    RegWriteW,
  output logic [RESULT_SRC_W-1:0] ResultSrcW
);

  typedef struct packed {
    logic                    reg_write;
    logic [RESULT_SRC_W-1:0] result_src;
    logic                    mem_write;
    logic                    jump;
    logic                    beq;
    logic                    bne;
    logic                    blt;
    logic                    bge;
    logic                    jalr;
    logic                    alu_src;
    logic [ALU_CTRL_W-1:0]   alu_control;
  } ctrl_t;

  typedef struct packed {
    logic                    reg_write;
    logic [RESULT_SRC_W-1:0] result_src;
    logic                    mem_write;
  } ctrl_m_t;

  ctrl_t   ctrl_d, de;
  ctrl_m_t em, mw;
  logic    branch_d, illegal_op_d, blt_d, bge_d, branch_ok_d, lt_e;

  wire unused_f7 = ^{f7[6], f7[4:0]};

  single_cycle_controller #(
    .ALU_CTRL_W  (ALU_CTRL_W),
    .IMM_SRC_W   (IMM_SRC_W),
    .RESULT_SRC_W(RESULT_SRC_W)
  ) u_decode (
    .opcode     (opcode),
    .f3         (f3),
    .f7_5       (f7[5]),
    .reg_write  (ctrl_d.reg_write),
    .result_src (ctrl_d.result_src),
    .mem_write  (ctrl_d.mem_write),
    .jump       (ctrl_d.jump),
    .branch     (branch_d),
    .beq        (ctrl_d.beq),
    .bne        (ctrl_d.bne),
    .alu_control(ctrl_d.alu_control),
    .alu_src    (ctrl_d.alu_src),
    .jalr       (ctrl_d.jalr),
    .imm_src    (ImmSrcD),
    .illegal_op (illegal_op_d)
  );

  // blt/bge reuse the branch decode's forced subtract; they only add the f3 match.
  assign blt_d       = ENABLE_LT && branch_d && (f3 == 3'b100);
  assign bge_d       = ENABLE_LT && branch_d && (f3 == 3'b101);
  assign ctrl_d.blt  = blt_d;
  assign ctrl_d.bge  = bge_d;
  assign branch_ok_d = ctrl_d.beq || ctrl_d.bne || blt_d || bge_d;
  assign IllegalD    = illegal_op_d || (branch_d && !branch_ok_d);

  // NOTE: the async clear acts on flops only; Decode stays combinational during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de <= '0;
      em <= '0;
      mw <= '0;
    end else begin
      de <= (FlushE || IllegalD) ? '0 : ctrl_d;
      em <= '{reg_write: de.reg_write, result_src: de.result_src, mem_write: de.mem_write};
      mw <= '{reg_write: em.reg_write, result_src: em.result_src, mem_write: 1'b0};
    end
  end

  assign lt_e = ENABLE_LT ? LtE : 1'b0;

  always_comb begin
    PCSrcE = 2'b00;
    if (de.jalr)
      PCSrcE = 2'b10;
    else if (de.jump || (de.beq && ZeroE) || (de.bne && !ZeroE) ||
             (de.blt && lt_e) || (de.bge && !lt_e))
      PCSrcE = 2'b01;
  end

  assign ALUControlE = de.alu_control;
  assign ALUSrcE     = de.alu_src;
  assign ResultSrcE0 = de.result_src[0];
  assign RegWriteE   = de.reg_write;
  assign MemWriteM   = em.mem_write;
  assign RegWriteM   = em.reg_write;
  assign RegWriteW   = mw.reg_write;
  assign ResultSrcW  = mw.result_src;

  wire unused_mw = mw.mem_write;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller: one instance with blt/bge enabled and one
// without, sharing all inputs; expected values are hand-computed per scenario.

module tb_pipelined_controller;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       flush_e, zero_e, lt_e;

  logic [2:0] lt_imm_src, lt_alu_control, base_imm_src, base_alu_control;
  logic [1:0] lt_pc_src, lt_result_src_w, base_pc_src, base_result_src_w;
  logic       lt_illegal, lt_alu_src, lt_result_src_e0, lt_reg_write_e, lt_mem_write_m;
  logic       lt_reg_write_m, lt_reg_write_w;
  logic       base_illegal, base_alu_src, base_result_src_e0, base_reg_write_e, base_mem_write_m;
  logic       base_reg_write_m, base_reg_write_w;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_controller #(.ENABLE_LT(1'b1)) u_lt (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .f7(f7),
    .FlushE(flush_e), .ZeroE(zero_e), .LtE(lt_e),
    .ImmSrcD(lt_imm_src), .IllegalD(lt_illegal), .ALUControlE(lt_alu_control),
    .ALUSrcE(lt_alu_src), .ResultSrcE0(lt_result_src_e0), .RegWriteE(lt_reg_write_e),
    .PCSrcE(lt_pc_src), .MemWriteM(lt_mem_write_m), .RegWriteM(lt_reg_write_m),
    .RegWriteW(lt_reg_write_w), .ResultSrcW(lt_result_src_w)
  );

  pipelined_controller #(.ENABLE_LT(1'b0)) u_base (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .f7(f7),
    .FlushE(flush_e), .ZeroE(zero_e), .LtE(lt_e),
    .ImmSrcD(base_imm_src), .IllegalD(base_illegal), .ALUControlE(base_alu_control),
    .ALUSrcE(base_alu_src), .ResultSrcE0(base_result_src_e0), .RegWriteE(base_reg_write_e),
    .PCSrcE(base_pc_src), .MemWriteM(base_mem_write_m), .RegWriteM(base_reg_write_m),
    .RegWriteW(base_reg_write_w), .ResultSrcW(base_result_src_w)
  );

  task automatic set_instr(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7);
    opcode = op;
    f3     = fn3;
    f7     = fn7;
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_e = 1'b0; zero_e = 1'b0; lt_e = 1'b0;
    set_instr(OP_NOP, 3'b000, 7'b0);
    #1;
    asserts++;
    if ({lt_alu_control, lt_alu_src, lt_result_src_e0, lt_reg_write_e, lt_pc_src,
         lt_mem_write_m, lt_reg_write_m, lt_reg_write_w, lt_result_src_w} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs: got E=%b/%b/%b/%b pc=%b M=%b/%b W=%b/%b want all 0",
               lt_alu_control, lt_alu_src, lt_result_src_e0, lt_reg_write_e, lt_pc_src,
               lt_mem_write_m, lt_reg_write_m, lt_reg_write_w, lt_result_src_w);
    end
    // Release with an add already in Decode: it reaches E on the first edge only.
    set_instr(OP_R, 3'b000, 7'b0);
    rst = 1'b1;
    step();
    asserts++;
    if ({lt_reg_write_e, lt_reg_write_m, lt_reg_write_w} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: got E/M/W regwrite=%b%b%b want 100",
               lt_reg_write_e, lt_reg_write_m, lt_reg_write_w);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step(); step(); step();
  endtask

  task automatic test_decode();
    set_instr(OP_STORE, 3'b010, 7'b0);
    #1;
    asserts++;
    if (lt_imm_src !== 3'b001 || lt_illegal !== 1'b0) begin
      failures++;
      $display("FAIL decode_sw: got imm=%b illegal=%b want 001 0", lt_imm_src, lt_illegal);
    end
    set_instr(7'b1111111, 3'b000, 7'b0);
    #1;
    asserts++;
    if (lt_illegal !== 1'b1) begin
      failures++;
      $display("FAIL decode_bad_opcode: got illegal=%b want 1", lt_illegal);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
  endtask

  task automatic test_rtype();
    set_instr(OP_R, 3'b000, 7'b0100000);
    step();
    asserts++;
    if (lt_alu_control !== 3'b001 || lt_alu_src !== 1'b0 || lt_reg_write_e !== 1'b1) begin
      failures++;
      $display("FAIL rtype_e: got alu=%b src=%b rw=%b want 001 0 1",
               lt_alu_control, lt_alu_src, lt_reg_write_e);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step();
    asserts++;
    if (lt_reg_write_m !== 1'b1) begin
      failures++;
      $display("FAIL rtype_m: got regwrite_m=%b want 1", lt_reg_write_m);
    end
    step();
    asserts++;
    if (lt_reg_write_w !== 1'b1 || lt_result_src_w !== 2'b00) begin
      failures++;
      $display("FAIL rtype_w: got rw=%b rs=%b want 1 00", lt_reg_write_w, lt_result_src_w);
    end
    // or (f3=110) and slt (f3=010) ALU codes
    set_instr(OP_R, 3'b110, 7'b0);
    step();
    asserts++;
    if (lt_alu_control !== 3'b011) begin
      failures++;
      $display("FAIL rtype_or: got alu=%b want 011", lt_alu_control);
    end
    set_instr(OP_R, 3'b010, 7'b0);
    step();
    asserts++;
    if (lt_alu_control !== 3'b101) begin
      failures++;
      $display("FAIL rtype_slt: got alu=%b want 101", lt_alu_control);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step(); step(); step();
  endtask

  task automatic test_load_store();
    set_instr(OP_LOAD, 3'b010, 7'b0);
    step();
    asserts++;
    if (lt_result_src_e0 !== 1'b1 || lt_alu_src !== 1'b1) begin
      failures++;
      $display("FAIL lw_e: got rs0=%b src=%b want 1 1", lt_result_src_e0, lt_alu_src);
    end
    set_instr(OP_STORE, 3'b010, 7'b0);
    step();
    set_instr(OP_NOP, 3'b000, 7'b0);
    step();
    asserts++;
    if (lt_result_src_w !== 2'b01 || lt_mem_write_m !== 1'b1) begin
      failures++;
      $display("FAIL lw_sw_c3: got rs_w=%b memwrite_m=%b want 01 1",
               lt_result_src_w, lt_mem_write_m);
    end
    step();
    asserts++;
    if (lt_reg_write_w !== 1'b0) begin
      failures++;
      $display("FAIL sw_w: got regwrite_w=%b want 0", lt_reg_write_w);
    end
    step(); step();
  endtask

  task automatic test_branches();
    set_instr(OP_BRANCH, 3'b000, 7'b0);
    zero_e = 1'b1;
    step();
    asserts++;
    if (lt_pc_src !== 2'b01 || lt_alu_control !== 3'b001) begin
      failures++;
      $display("FAIL beq_taken: got pc=%b alu=%b want 01 001", lt_pc_src, lt_alu_control);
    end
    zero_e = 1'b0;
    #1;
    asserts++;
    if (lt_pc_src !== 2'b00) begin
      failures++;
      $display("FAIL beq_not_taken: got pc=%b want 00", lt_pc_src);
    end
    set_instr(OP_BRANCH, 3'b001, 7'b0);
    step();
    asserts++;
    if (lt_pc_src !== 2'b01) begin
      failures++;
      $display("FAIL bne_taken: got pc=%b want 01", lt_pc_src);
    end
    zero_e = 1'b1;
    #1;
    asserts++;
    if (lt_pc_src !== 2'b00) begin
      failures++;
      $display("FAIL bne_not_taken: got pc=%b want 00", lt_pc_src);
    end
    set_instr(OP_JALR, 3'b000, 7'b0);
    step();
    asserts++;
    if (lt_pc_src !== 2'b10) begin
      failures++;
      $display("FAIL jalr: got pc=%b want 10", lt_pc_src);
    end
    set_instr(OP_JAL, 3'b000, 7'b0);
    step();
    asserts++;
    if (lt_pc_src !== 2'b01) begin
      failures++;
      $display("FAIL jal_e: got pc=%b want 01", lt_pc_src);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step(); step();
    asserts++;
    if (lt_result_src_w !== 2'b10 || lt_reg_write_w !== 1'b1) begin
      failures++;
      $display("FAIL jal_w: got rs=%b rw=%b want 10 1", lt_result_src_w, lt_reg_write_w);
    end
    zero_e = 1'b0;
    step(); step();
  endtask

  task automatic test_flush();
    set_instr(OP_R, 3'b000, 7'b0100000);
    step();
    set_instr(OP_R, 3'b000, 7'b0);
    flush_e = 1'b1;
    step();
    flush_e = 1'b0;
    asserts++;
    if (lt_alu_control !== 3'b000 || lt_reg_write_e !== 1'b0) begin
      failures++;
      $display("FAIL flush_e: got alu=%b rw=%b want 000 0", lt_alu_control, lt_reg_write_e);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step(); step();
    asserts++;
    if (lt_reg_write_w !== 1'b0) begin
      failures++;
      $display("FAIL flush_w: got regwrite_w=%b want 0", lt_reg_write_w);
    end
    step();
  endtask

  task automatic test_back_to_back();
    // The instruction already in E advances; only the one in Decode is squashed.
    set_instr(OP_R, 3'b000, 7'b0);
    step();
    set_instr(OP_LOAD, 3'b010, 7'b0);
    flush_e = 1'b1;
    step();
    flush_e = 1'b0;
    asserts++;
    if (lt_reg_write_m !== 1'b1 || lt_reg_write_e !== 1'b0 || lt_result_src_e0 !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: got rw_m=%b rw_e=%b rs0_e=%b want 1 0 0",
               lt_reg_write_m, lt_reg_write_e, lt_result_src_e0);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step(); step(); step();
  endtask

  task automatic test_lt();
    set_instr(OP_BRANCH, 3'b100, 7'b0);
    lt_e = 1'b1;
    #1;
    asserts++;
    if (lt_illegal !== 1'b0 || base_illegal !== 1'b1) begin
      failures++;
      $display("FAIL blt_illegal: got lt=%b base=%b want 0 1", lt_illegal, base_illegal);
    end
    step();
    asserts++;
    if (lt_pc_src !== 2'b01 || base_pc_src !== 2'b00 || lt_alu_control !== 3'b001) begin
      failures++;
      $display("FAIL blt_taken: got lt_pc=%b base_pc=%b alu=%b want 01 00 001",
               lt_pc_src, base_pc_src, lt_alu_control);
    end
    lt_e = 1'b0;
    #1;
    asserts++;
    if (lt_pc_src !== 2'b00) begin
      failures++;
      $display("FAIL blt_not_taken: got pc=%b want 00", lt_pc_src);
    end
    set_instr(OP_BRANCH, 3'b101, 7'b0);
    #1;
    asserts++;
    if (base_illegal !== 1'b1) begin
      failures++;
      $display("FAIL bge_illegal_base: got illegal=%b want 1", base_illegal);
    end
    step();
    asserts++;
    if (lt_pc_src !== 2'b01 || base_pc_src !== 2'b00) begin
      failures++;
      $display("FAIL bge_taken: got lt_pc=%b base_pc=%b want 01 00", lt_pc_src, base_pc_src);
    end
    set_instr(OP_NOP, 3'b000, 7'b0);
    step(); step(); step();
  endtask

  task automatic test_reset_midrun();
    set_instr(OP_R, 3'b000, 7'b0);
    step();
    set_instr(OP_NOP, 3'b000, 7'b0);
    step();
    set_instr(OP_BRANCH, 3'b000, 7'b0);
    step();
    zero_e = 1'b1;
    #1;
    asserts++;
    if (lt_pc_src !== 2'b01 || lt_reg_write_w !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got pc=%b rw_w=%b want 01 1", lt_pc_src, lt_reg_write_w);
    end
    rst = 1'b0;
    #1;
    asserts++;
    if (lt_pc_src !== 2'b00 || lt_reg_write_w !== 1'b0 || lt_alu_control !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: got pc=%b rw_w=%b alu=%b want 00 0 000",
               lt_pc_src, lt_reg_write_w, lt_alu_control);
    end
    zero_e = 1'b0;
    set_instr(OP_NOP, 3'b000, 7'b0);
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_rtype();
    test_load_store();
    test_branches();
    test_flush();
    test_back_to_back();
    test_lt();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
Control path for the 5-stage pipelined RV32I core. Decodes opcode/f3/f7 in Decode through single_cycle_controller and carries the resulting control word through the D/E, E/M and M/W pipeline registers. Resolves the PC source in Execute from ALU flags. Supports Execute flush for hazards and taken branches, and an optional blt/bge extension.

Parameters:
ALU_CTRL_W, 3, width of ALU control field
IMM_SRC_W, 3, width of immediate-select field
RESULT_SRC_W, 2, width of writeback-select field
ENABLE_LT, 0, 1 = decode blt (f3=100) and bge (f3=101) branches; 0 = such encodings are illegal

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low
opcode  in  7  instruction[6:0], Decode stage
f3  in  3  instruction[14:12], Decode stage
f7  in  7  instruction[31:25], Decode stage
FlushE  in  1  from hazard unit; loads a bubble into D/E
ZeroE  in  1  ALU zero flag, Execute
LtE  in  1  ALU signed less-than flag, Execute; ignored when ENABLE_LT=0
ImmSrcD  out  IMM_SRC_W  immediate select, Decode (combinational)
IllegalD  out  1  opcode/f3 not in the supported set (combinational)
ALUControlE  out  ALU_CTRL_W  ALU op, Execute
ALUSrcE  out  1  1 = immediate operand B
ResultSrcE0  out  1  ResultSrcE[0], load-use detection
RegWriteE  out  1  Execute write-enable, hazard unit
PCSrcE  out  2  00 PC+4, 01 PC+ImmExt, 10 ALU result (jalr)
MemWriteM  out  1  data-memory write enable
RegWriteM  out  1  forwarding qualifier
RegWriteW  out  1  register-file write enable
ResultSrcW  out  RESULT_SRC_W  00 ALU, 01 memory, 10 PC+4

Behaviour:
- Decode is combinational: control word from single_cycle_controller (RegWrite, ResultSrc, MemWrite, Jump, Beq, Bne, ALUControl, ALUSrc, Jalr, ImmSrc).
- When ENABLE_LT=1, this block adds Blt and Bge for opcode 1100011, f3 100/101.
- ALU encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt. Blt/Bge force sub.
- IllegalD=1 when the opcode is outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111}, or on a branch f3 not enabled. Illegal instructions enter D/E as a bubble.
- Bubble = all control fields 0: no register write, no memory write, no branch or jump, PCSrc=00.
- Pipeline registers D/E, E/M and M/W capture on every rising clk. There is no stall input; the datapath holds Fetch/Decode itself.
- Latency: a field decoded in cycle n appears in E at n+1, in M at n+2 and in W at n+3.
- E/M carries RegWrite, ResultSrc and MemWrite. M/W carries RegWrite and ResultSrc.
- FlushE=1 at an edge makes D/E load a bubble. E/M and M/W advance normally, so the flushed slot propagates as a bubble.
- PCSrcE (combinational from E registers):
  - 10 if JalrE;
  - else 01 if JumpE, (BeqE & ZeroE), (BneE & ~ZeroE), (BltE & LtE) or (BgeE & ~LtE);
  - else 00.
- The hazard unit drives FlushE from PCSrcE!=00. On that next edge the taken-branch instruction itself moves on to E/M as a normal entry; only the following Decode instruction is squashed.
- Reset: rst low clears all D/E, E/M and M/W fields to 0 immediately, without waiting for clk. While rst is low, every E/M/W output is 0 and PCSrcE=00. This holds even if a branch sits in Execute mid-operation. Decode outputs stay combinational.
- Release of rst takes effect at the first following edge; the pipeline holds 3 bubbles until real instructions reach W.
- With ENABLE_LT=0, blt/bge encodings give IllegalD=1 and behave as bubbles.

Test Plan:
- Reset: rst low mid-run with a beq in E and ZeroE=1 -> PCSrcE=00 and RegWriteW=0 immediately, before any clk edge.
- R-type: opcode=0110011, f3=000, f7=0100000 in cycle 0 -> ALUControlE=001 and ALUSrcE=0 at cycle 1; RegWriteM=1 at 2; RegWriteW=1 and ResultSrcW=00 at 3.
- Load then store: lw (0000011) -> ResultSrcE0=1 at 1 and ResultSrcW=01 at 3. Following sw (0100011) -> MemWriteM=1 at 3 and RegWriteW=0 at 4.
- Branches:
  - beq with ZeroE=1 -> PCSrcE=01; with ZeroE=0 -> 00.
  - bne with ZeroE=0 -> 01.
  - jalr -> PCSrcE=10.
  - jal -> PCSrcE=01 and ResultSrcW=10 three cycles after decode.
- Flush: add in D with FlushE=1 -> ALUControlE=000 and RegWriteE=0 next cycle; RegWriteW=0 two cycles later.
- ENABLE_LT: blt (f3=100) with LtE=1 -> PCSrcE=01 when ENABLE_LT=1. With ENABLE_LT=0 -> IllegalD=1 and PCSrcE=00.
